// File: rtl/gcache_types_pkg.sv
// Shared widths, beat-packed line type and adaptor state encoding for the
// cacheline <-> memory burst adaptor.
package gcache_types_pkg;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int CNT_W   = $clog2(BEATS);

  typedef logic [LINE_W-1:0]               line_t;
  typedef logic [BURST_W-1:0]              beat_t;
  // Same bit layout as line_t; element 0 holds the LSB beat.
  typedef logic [BEATS-1:0][BURST_W-1:0]   beats_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adaptor_state_e;
endpackage

// File: rtl/gcache_line_adaptor.sv
// Splits one cacheline request into a BEATS x BURST_W memory burst (fill or writeback)
// and returns a one-cycle resp_o; the assembled fill line is held until the next read beat.
module gcache_line_adaptor
  import gcache_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  adaptor_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  beats_t            wline_q, wline_d;
  beats_t            rline_q, rline_d;
  logic [31:0]       addr_q, addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wline_q <= '0;
      rline_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wline_d = wline_q;
    rline_d = rline_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        // Writeback wins so a dirty victim leaves before its replacement arrives.
        if (write_i) begin
          state_d = WR;
          wline_d = line_i;
          addr_d  = address_i;
          cnt_d   = '0;
        end else if (read_i) begin
          state_d = RD;
          addr_d  = address_i;
          cnt_d   = '0;
        end
      end
      RD: begin
        if (resp_i) begin
          rline_d[cnt_q] = burst_i;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign read_o    = (state_q == RD);
  assign write_o   = (state_q == WR);
  assign resp_o    = (state_q == DONE);
  assign address_o = {addr_q[31:5], 5'b0};
  assign burst_o   = (state_q == WR) ? wline_q[cnt_q] : '0;
  assign line_o    = rline_q;

endmodule

// File: tb/tb_gcache_line_adaptor.sv
// Randomised bench for gcache_line_adaptor: transaction-level reference model checked every
// cycle, plus literal expectations for the directed fill/writeback/reset scenarios.
module tb_gcache_line_adaptor;
  import gcache_types_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  gcache_line_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int resp_cnt = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: which transfer is open, how many beats have been strobed,
  // and what the cache should currently see.
  int           m_busy  = 0;   // 0 none, 1 fill, 2 writeback
  int           m_beats = 0;
  bit           m_done  = 1'b0;
  logic [255:0] m_line  = '0;
  logic [255:0] m_wline = '0;
  logic [31:0]  m_addr  = '0;
  logic [63:0]  wbeats[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_beats = 0; m_done = 1'b0;
      m_line = '0; m_wline = '0; m_addr = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy == 0) begin
      if (write_i) begin
        m_busy = 2; m_wline = line_i; m_addr = address_i; m_beats = 0;
      end else if (read_i) begin
        m_busy = 1; m_addr = address_i; m_beats = 0;
      end
    end else if (resp_i) begin
      if (m_busy == 1) m_line[m_beats*64 +: 64] = burst_i;
      else wbeats.push_back(burst_o);
      m_beats++;
      if (m_beats == 4) begin
        m_busy = 0; m_beats = 0; m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("read_o", read_o, m_busy == 1);
    chk("write_o", write_o, m_busy == 2);
    chk("resp_o", resp_o, m_done);
    chk("address_o", address_o, {m_addr[31:5], 5'b0});
    chk("line_o", line_o, m_line);
    if (m_busy == 2) chk("burst_o", burst_o, m_wline[m_beats*64 +: 64]);
    if (resp_o) resp_cnt++;
  end

  // Issue one request; pat gives the resp_i strobe pattern LSB first (all ones once exhausted).
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] a,
                      input logic [255:0] wl, input logic [255:0] rl,
                      input logic [31:0] pat, input bit hold_done);
    int k = 0;
    int cyc = 0;
    bit s;
    write_i = wr; read_i = rd; address_i = a; line_i = wl;
    @(negedge clk);
    while (k < 4 && cyc < 40) begin
      s = (cyc < 32) ? pat[cyc] : 1'b1;
      cyc++;
      resp_i  = s;
      burst_i = s ? rl[k*64 +: 64] : {$urandom, $urandom};
      if (s) k++;
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = '0;
    cyc = 0;
    while (!resp_o && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!resp_o) begin
      n_bad++;
      $display("FAIL resp_timeout: got resp_o=%b want 1", resp_o);
    end
    if (hold_done) @(negedge clk);
    write_i = 1'b0; read_i = 1'b0;
    @(negedge clk);
  endtask

  logic [255:0] t1_line;
  logic [255:0] wl, rl;
  logic [63:0]  exp_w [4];
  logic [31:0]  a;
  int           rc;
  bit           wr, rd;

  initial begin
    t1_line = {64'h4, 64'h3, 64'h2, 64'h1};
    repeat (3) @(negedge clk);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_line_o", line_o, '0);
    chk("rst_address_o", address_o, '0);
    rst = 1'b0;
    @(negedge clk);

    // Fill with back-to-back strobes
    xfer(1'b0, 1'b1, 32'h0000_1000, '0, t1_line, 32'hFFFF_FFFF, 1'b0);
    chk("t1_line", line_o, t1_line);
    chk("t1_resp_cnt", resp_cnt, 1);
    chk("t1_read_low", read_o, 1'b0);

    // Writeback, address low bits cleared
    wbeats.delete();
    wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    exp_w = '{{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}};
    xfer(1'b1, 1'b0, 32'h1234_567F, wl, '0, 32'hFFFF_FFFF, 1'b0);
    chk("t2_address_o", address_o, 32'h1234_5660);
    chk("t2_nbeats", wbeats.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_beat%0d", i), wbeats[i], exp_w[i]);
    chk("t2_line_kept", line_o, t1_line);
    chk("t2_resp_cnt", resp_cnt, 2);

    // Both requests high: writeback first, then fill on re-issue
    wbeats.delete();
    wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b1, 1'b1, 32'h0000_2040, wl, rl, 32'hFFFF_FFFF, 1'b0);
    chk("t3_wr_first", wbeats.size(), 4);
    chk("t3_line_kept", line_o, t1_line);
    xfer(1'b0, 1'b1, 32'h0000_2040, '0, rl, 32'hFFFF_FFFF, 1'b0);
    chk("t3_fill", line_o, rl);

    // Fill with strobe gaps 1,0,0,1,1,0,1
    xfer(1'b0, 1'b1, 32'h0000_3000, '0, t1_line, 32'b1011001, 1'b0);
    chk("t4_line", line_o, t1_line);

    // Reset after two fill beats
    rc = resp_cnt;
    read_i = 1'b1; address_i = 32'h0000_4000;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = 64'hF0 + 64'(i);
      @(negedge clk);
    end
    resp_i = 1'b0;
    #2 rst = 1'b1;
    #1 chk("t5_read_drop", read_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; read_i = 1'b0;
    @(negedge clk);
    chk("t5_no_resp", resp_cnt, rc);
    chk("t5_line_cleared", line_o, '0);
    xfer(1'b0, 1'b1, 32'h0000_4000, '0, t1_line, 32'hFFFF_FFFF, 1'b0);
    chk("t5_recover", line_o, t1_line);

    // Strobes in IDLE and requests held through DONE
    rc = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("t6_idle_strobe", resp_cnt, rc);
    chk("t6_idle_line", line_o, t1_line);
    rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b0, 1'b1, 32'h0000_5000, '0, rl, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_single_resp", resp_cnt, rc + 1);
    chk("t6_no_reissue", read_o, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom;
      wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      wbeats.delete();
      xfer(wr, rd, a, wl, rl, $urandom, 1'b0);
      if (wr) begin
        chk("rnd_wr_nbeats", wbeats.size(), 4);
      end else begin
        chk("rnd_fill", line_o, rl);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
